// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/D memory port arbiter.
// Size encoding, requester identity, response slot and store lane rules.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    size_e      size;
    logic       is_unsigned;
    logic [1:0] off;
    logic       err;
    logic       is_store;
  } slot_t;

  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(size_e size, logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Store byte-lane replication / enables and load lane extraction with extension.
// Purely combinational; the store side sees the request, the load side sees the slot.
module lsu_lane_align
  import mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_lanes,
  input  logic [1:0]      ld_size,
  input  logic [1:0]      ld_off,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = store_be(size_e'(st_size), st_off);
    st_lanes = st_wdata;
    case (size_e'(st_size))
      SZ_B:    st_lanes = {4{st_wdata[7:0]}};
      SZ_H:    st_lanes = {2{st_wdata[15:0]}};
      default: st_lanes = st_wdata;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
    ld_data = '0;
    case (size_e'(ld_size))
      SZ_B:    ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      SZ_W:    ld_data = ld_rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF, D) arbiter for a single-port byte-writable RAM with a
// one-deep response slot; alternating priority bounds each side's wait to 1 cycle.
//
// prio   | meaning
// OWN_D  | D wins when both request (reset value)
// OWN_IF | IF wins when both request
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH_W = 7,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  logic [XLEN-1:0]    if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [XLEN-1:0]    if_rdata_o,
  input  logic               d_req_i,
  input  logic               d_we_i,
  input  logic [1:0]         d_size_i,
  input  logic               d_unsigned_i,
  input  logic [XLEN-1:0]    d_addr_i,
  input  logic [XLEN-1:0]    d_wdata_i,
  output logic               d_gnt_o,
  output logic               d_rvalid_o,
  output logic [XLEN-1:0]    d_rdata_o,
  output logic               d_err_o,
  output logic [DEPTH_W-1:0] mem_addr_o,
  output logic [3:0]         mem_we_o,
  output logic [XLEN-1:0]    mem_wdata_o,
  input  logic [XLEN-1:0]    mem_rdata_i
);

  owner_e          prio;
  slot_t           slot;
  slot_t           slot_nxt;
  logic            gnt_if;
  logic            gnt_d;
  logic            d_err_now;
  logic [1:0]      d_off;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_lanes;
  logic [XLEN-1:0] ld_data;
  logic            unused_addr_bits;

  assign d_off     = d_addr_i[1:0];
  assign d_err_now = is_misaligned(size_e'(d_size_i), d_off);

  // Addresses wrap: bits above the RAM depth and IF byte-offset bits are dropped.
  assign unused_addr_bits = ^{if_addr_i[XLEN-1:DEPTH_W+2], if_addr_i[1:0],
                              d_addr_i[XLEN-1:DEPTH_W+2]};

  always_comb begin
    gnt_d  = !rst && d_req_i && (!if_req_i || prio == OWN_D);
    gnt_if = !rst && if_req_i && !gnt_d;
  end

  assign if_gnt_o    = gnt_if;
  assign d_gnt_o     = gnt_d;
  assign mem_addr_o  = gnt_d ? d_addr_i[DEPTH_W+1:2] : if_addr_i[DEPTH_W+1:2];
  assign mem_we_o    = (gnt_d && d_we_i && !d_err_now) ? st_be : 4'b0000;
  assign mem_wdata_o = st_lanes;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .st_size     (d_size_i),
    .st_off      (d_off),
    .st_wdata    (d_wdata_i),
    .st_be       (st_be),
    .st_lanes    (st_lanes),
    .ld_size     (slot.size),
    .ld_off      (slot.off),
    .ld_unsigned (slot.is_unsigned),
    .ld_rdata    (mem_rdata_i),
    .ld_data     (ld_data)
  );

  always_comb begin
    slot_nxt       = '0;
    slot_nxt.valid = gnt_if || gnt_d;
    slot_nxt.owner = gnt_d ? OWN_D : OWN_IF;
    if (gnt_d) begin
      slot_nxt.size        = size_e'(d_size_i);
      slot_nxt.is_unsigned = d_unsigned_i;
      slot_nxt.off         = d_off;
      slot_nxt.err         = d_err_now;
      slot_nxt.is_store    = d_we_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      prio <= OWN_D;
    end else begin
      slot <= slot_nxt;
      if (gnt_d)       prio <= OWN_IF;
      else if (gnt_if) prio <= OWN_D;
    end
  end

  assign if_rvalid_o = slot.valid && (slot.owner == OWN_IF);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rvalid_o  = slot.valid && (slot.owner == OWN_D);
  assign d_err_o     = d_rvalid_o && slot.err;
  assign d_rdata_o   = (d_rvalid_o && !slot.err && !slot.is_store) ? ld_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: byte-level reference memory and
// arbitration model predict grants and responses; a monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i, d_unsigned_i;
  logic [1:0]  d_size_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic [6:0]  mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DEPTH_W(7), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_unsigned_i(d_unsigned_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // RAM behind the arbiter: byte writes, registered read.
  logic [31:0] ram [0:127];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_we_o[k]) ram[mem_addr_o][8*k +: 8] <= mem_wdata_o[8*k +: 8];
    mem_rdata_i <= ram[mem_addr_o];
  end

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  ref_mem [0:511];
  bit          prio_d;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  cap_we;
  logic [31:0] cap_wdata;
  logic [6:0]  cap_addr;
  logic        last_if_rvalid, last_d_rvalid, last_d_err;
  logic [31:0] last_if_rdata, last_d_rdata;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_mem[widx*4+3], ref_mem[widx*4+2], ref_mem[widx*4+1], ref_mem[widx*4]};
  endfunction

  task automatic drive_cycle(input bit r, input bit ireq, input logic [31:0] iaddr,
                             input bit dreq, input bit we, input logic [1:0] sz,
                             input bit uns, input logic [31:0] daddr, input logic [31:0] wd,
                             output bit g_if, output bit g_d);
    int          off, n, didx, iidx, base;
    bit          mis;
    logic [3:0]  ewe;
    logic [31:0] v;
    exp_t        e;
    @(negedge clk);
    rst = r; if_req_i = ireq; if_addr_i = iaddr; d_req_i = dreq; d_we_i = we;
    d_size_i = sz; d_unsigned_i = uns; d_addr_i = daddr; d_wdata_i = wd;
    #1;
    cap_we = mem_we_o; cap_wdata = mem_wdata_o; cap_addr = mem_addr_o;
    g_d  = !r && dreq && (!ireq || prio_d);
    g_if = !r && ireq && !g_d;
    chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, g_if});
    chk("d_gnt", {31'b0, d_gnt_o}, {31'b0, g_d});
    off  = int'(daddr % 4);
    didx = int'((daddr / 4) % 128);
    iidx = int'((iaddr / 4) % 128);
    mis  = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    n    = 1 << sz;
    base = didx * 4 + off;
    ewe  = 4'b0;
    if (g_d) begin
      chk("mem_addr_d", {25'b0, mem_addr_o}, didx);
      v = 32'b0;
      if (!mis && we) begin
        for (int k = 0; k < n; k++) begin
          ref_mem[base+k] = wd[8*k +: 8];
          ewe[off+k] = 1'b1;
          chk("mem_wdata_lane", {24'b0, mem_wdata_o[8*(off+k) +: 8]}, {24'b0, wd[8*k +: 8]});
        end
      end else if (!mis) begin
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[base+k];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      end
      e.is_d = 1'b1; e.data = v; e.err = mis;
      expq.push_back(e);
    end
    if (g_if) begin
      chk("mem_addr_if", {25'b0, mem_addr_o}, iidx);
      e.is_d = 1'b0; e.data = ref_word(iidx); e.err = 1'b0;
      expq.push_back(e);
    end
    chk("mem_we", {28'b0, mem_we_o}, {28'b0, ewe});
    if (r)         prio_d = 1'b1;
    else if (g_d)  prio_d = 1'b0;
    else if (g_if) prio_d = 1'b1;
  endtask

  task automatic idle(input bit r);
    bit a, b;
    drive_cycle(r, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, a, b);
  endtask

  task automatic expect_d(input string name, input logic [31:0] data, input bit err);
    chk({name, "_rvalid"}, {31'b0, last_d_rvalid}, 32'd1);
    chk({name, "_rdata"}, last_d_rdata, data);
    chk({name, "_err"}, {31'b0, last_d_err}, {31'b0, err});
  endtask

  // Monitor: every response is matched against the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      last_if_rvalid = if_rvalid_o; last_if_rdata = if_rdata_o;
      last_d_rvalid  = d_rvalid_o;  last_d_rdata  = d_rdata_o; last_d_err = d_err_o;
      if (if_rvalid_o || d_rvalid_o) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: got if=%0b d=%0b expected none", if_rvalid_o, d_rvalid_o);
        end else begin
          e = expq.pop_front();
          chk("resp_owner", {30'b0, if_rvalid_o, d_rvalid_o}, {30'b0, !e.is_d, e.is_d});
          if (e.is_d) begin
            chk("d_rdata", d_rdata_o, e.data);
            chk("d_err", {31'b0, d_err_o}, {31'b0, e.err});
          end else begin
            chk("if_rdata", if_rdata_o, e.data);
          end
        end
      end else if (expq.size() != 0) begin
        checks++; errors++;
        $display("FAIL missing_rvalid: got no rvalid expected %0d pending", expq.size());
        expq.delete();
      end
      if (!if_rvalid_o) chk("if_rdata_idle", if_rdata_o, 32'h0);
      if (!d_rvalid_o) chk("d_idle", d_rdata_o | {31'b0, d_err_o}, 32'h0);
    end
  end

  initial begin
    bit          gi, gd, ip, dp, pwe, puns;
    logic [31:0] saved, pia, pda, pwd;
    logic [1:0]  psz;
    prio_d = 1'b1;
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_size_i = '0; d_unsigned_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    for (int w = 0; w < 128; w++) begin
      saved = (w == 2) ? 32'hDEAD_BEEF : $urandom;
      ram[w] = saved;
      for (int k = 0; k < 4; k++) ref_mem[w*4+k] = saved[8*k +: 8];
    end

    repeat (3) idle(1'b1);
    idle(1'b0);

    // IF alone
    drive_cycle(0, 1, 32'h08, 0, 0, 2'd0, 0, 32'h0, 32'h0, gi, gd);
    chk("if_only_gnt", {31'b0, gi}, 32'd1);
    idle(1'b0);
    chk("if_only_rvalid", {31'b0, last_if_rvalid}, 32'd1);
    chk("if_only_rdata", last_if_rdata, 32'hDEAD_BEEF);

    // Both requesting: alternate starting with D
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, 32'h0C, 1, 0, 2'd2, 0, 32'h10, 32'h0, gi, gd);
      chk("arb_seq_d", {31'b0, gd}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    idle(1'b0);

    // SB / LB / LBU
    drive_cycle(0, 0, 0, 1, 1, 2'd0, 0, 32'h07, 32'h0000_00AB, gi, gd);
    chk("sb_we", {28'b0, cap_we}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    drive_cycle(0, 0, 0, 1, 0, 2'd0, 0, 32'h07, 32'h0, gi, gd);
    drive_cycle(0, 0, 0, 1, 0, 2'd0, 1, 32'h07, 32'h0, gi, gd);
    expect_d("lb", 32'hFFFF_FFAB, 1'b0);
    idle(1'b0);
    expect_d("lbu", 32'h0000_00AB, 1'b0);

    // SH / LH / LHU
    drive_cycle(0, 0, 0, 1, 1, 2'd1, 0, 32'h12, 32'h0000_8001, gi, gd);
    chk("sh_we", {28'b0, cap_we}, 32'hC);
    chk("sh_addr", {25'b0, cap_addr}, 32'd4);
    drive_cycle(0, 0, 0, 1, 0, 2'd1, 0, 32'h12, 32'h0, gi, gd);
    drive_cycle(0, 0, 0, 1, 0, 2'd1, 1, 32'h12, 32'h0, gi, gd);
    expect_d("lh", 32'hFFFF_8001, 1'b0);
    idle(1'b0);
    expect_d("lhu", 32'h0000_8001, 1'b0);

    // Misaligned accesses
    saved = ref_word(1);
    drive_cycle(0, 0, 0, 1, 0, 2'd2, 0, 32'h06, 32'h0, gi, gd);
    chk("lw_mis_we", {28'b0, cap_we}, 32'h0);
    drive_cycle(0, 0, 0, 1, 1, 2'd1, 0, 32'h05, 32'hFFFF_FFFF, gi, gd);
    expect_d("lw_mis", 32'h0, 1'b1);
    chk("sh_mis_we", {28'b0, cap_we}, 32'h0);
    drive_cycle(0, 0, 0, 1, 0, 2'd2, 0, 32'h04, 32'h0, gi, gd);
    expect_d("sh_mis", 32'h0, 1'b1);
    idle(1'b0);
    expect_d("lw_unchanged", saved, 1'b0);

    // Reset in a would-be grant cycle
    drive_cycle(1, 1, 32'h20, 1, 0, 2'd2, 0, 32'h24, 32'h0, gi, gd);
    chk("rst_no_gnt", {30'b0, gi, gd}, 32'd0);
    drive_cycle(0, 1, 32'h20, 1, 0, 2'd2, 0, 32'h24, 32'h0, gi, gd);
    chk("post_rst_no_rvalid", {30'b0, last_if_rvalid, last_d_rvalid}, 32'd0);
    chk("post_rst_first_d", {31'b0, gd}, 32'd1);
    idle(1'b0);
    idle(1'b0);

    // Randomized traffic with held requests and occasional reset
    ip = 0; dp = 0; pia = 0; pda = 0; pwd = 0; psz = 0; pwe = 0; puns = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!ip && ($urandom % 3 == 0)) begin ip = 1; pia = $urandom; end
      if (!dp && ($urandom % 2 == 0)) begin
        dp = 1; pda = $urandom; pwd = $urandom; pwe = $urandom % 2 == 0;
        puns = $urandom % 2 == 0;
        psz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      end
      drive_cycle($urandom % 64 == 0, ip, pia, dp, pwe, psz, puns, pda, pwd, gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end
    idle(1'b0);
    idle(1'b0);
    chk("queue_drained", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
